// File: rtl/shifter_palette_if.sv
// rtl/shifter_palette_if.sv - CPU palette register-access handshake bundle
interface shifter_palette_if;
  logic        req;
  logic        rw;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ack;

  modport master (
    output req, rw, addr, din,
    input  dout, ack
  );

  modport slave (
    input  req, rw, addr, din,
    output dout, ack
  );
endinterface

// File: rtl/shifter_palette.sv
// rtl/shifter_palette.sv - 16-entry colour palette lookup with CPU access; STE_PALETTE_EN selects 12-bit STE entries
module shifter_palette #(
  parameter bit PIPE_BLANK = 1'b1
) (
  input  logic             pixClk,
  input  logic             nReset,
  input  logic [1:0]       rez,
  input  logic [3:0]       color_index,
  input  logic             DE,
  input  logic             blank_n,
  shifter_palette_if.slave bus,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b
);

`ifdef STE_PALETTE_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif
  localparam int EW = 3 * CW;

  logic [EW-1:0] pal_q [16];
  logic [EW-1:0] pal_d [16];
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    rez_q, rez_d;
  logic          de_q, de_d;
  logic          blank_q, blank_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          ack_q, ack_d;
  logic [15:0]   dout_q, dout_d;

  logic          de_s, blank_s, commit, mono_p;
  logic [EW-1:0] ent;
  logic          unused_din;

  // Widen one stored channel to the 4-bit DAC code.
  function automatic logic [3:0] expand(input logic [CW-1:0] c);
`ifdef STE_PALETTE_EN
    return {c[2:0], c[3]};
`else
    return {c[2:0], c[2]};
`endif
  endfunction

  // Pick the stored channel bits out of a CPU write word.
  function automatic logic [EW-1:0] pack_write(input logic [15:0] d);
`ifdef STE_PALETTE_EN
    return d[11:0];
`else
    return {d[10:8], d[6:4], d[2:0]};
`endif
  endfunction

  // Rebuild the CPU-visible register word from a stored entry.
  function automatic logic [15:0] read_word(input logic [EW-1:0] e);
`ifdef STE_PALETTE_EN
    return {4'b0, e};
`else
    return {5'b0, e[8:6], 1'b0, e[5:3], 1'b0, e[2:0]};
`endif
  endfunction

  assign unused_din = ^bus.din;
  assign de_s       = PIPE_BLANK ? de_q : DE;
  assign blank_s    = PIPE_BLANK ? blank_q : blank_n;
  assign commit     = bus.req & ~ack_q;

  // Stage 1 captures the pixel and its timing qualifiers.
  always_comb begin
    idx_d   = color_index;
    rez_d   = rez;
    de_d    = DE;
    blank_d = blank_n;
  end

  // Stage 2 colour select: blank beats border beats mono beats palette.
  always_comb begin
    r_d    = 4'h0;
    g_d    = 4'h0;
    b_d    = 4'h0;
    ent    = de_s ? pal_q[idx_q] : pal_q[0];
    mono_p = idx_q[0] ^ pal_q[0][0];
    if (!blank_s) begin
      r_d = 4'h0;
    end else if (de_s && rez_q == 2'd2) begin
      {r_d, g_d, b_d} = mono_p ? 12'h000 : 12'hFFF;
    end else begin
      r_d = expand(ent[EW-1:2*CW]);
      g_d = expand(ent[2*CW-1:CW]);
      b_d = expand(ent[CW-1:0]);
    end
  end

  // One palette access per req pulse; ack simply follows req once committed.
  always_comb begin
    pal_d  = pal_q;
    dout_d = dout_q;
    ack_d  = bus.req;
    if (commit) begin
      if (bus.rw) dout_d = read_word(pal_q[bus.addr]);
      else        pal_d[bus.addr] = pack_write(bus.din);
    end
  end

  // Pipeline registers.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      idx_q   <= '0;
      rez_q   <= '0;
      de_q    <= 1'b0;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      idx_q   <= idx_d;
      rez_q   <= rez_d;
      de_q    <= de_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  // Palette storage and CPU handshake state.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
      ack_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      pal_q  <= pal_d;
      ack_q  <= ack_d;
      dout_q <= dout_d;
    end
  end

  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign bus.ack  = ack_q;
  assign bus.dout = dout_q;

endmodule
